// File: rtl/multi_sync_debounce_pkg.sv
// Shared constants, types and helpers for the multi-channel input conditioner.
// Optional feature macro: SYNC_GLITCH_FLAG_EN (sticky rejected-glitch flags).
package multi_sync_debounce_pkg;

    localparam int SYNC_MIN_STAGES = 2;
    localparam int DB_MIN_CYCLES   = 1;

    // Debounce counter width: must hold values up to DB_CYCLES-1 (sized for DB_CYCLES).
    function automatic int cnt_width(input int db_cycles);
        return (db_cycles < 1) ? 1 : $clog2(db_cycles + 1);
    endfunction

    // Per-channel conditioned outputs.
    typedef struct packed {
        logic level;
        logic rise;
        logic fall;
    } chan_status_t;

endpackage

// File: rtl/multi_sync_debounce_chan.sv
// One conditioner channel: N-stage synchroniser, counter debounce filter,
// registered rise/fall pulses. Optional macro: SYNC_GLITCH_FLAG_EN.
module sync_db_chan
    import multi_sync_debounce_pkg::*;
#(
    parameter int   SYNC_STAGES = 2,
    parameter int   DB_CYCLES   = 16,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         async_in,
`ifdef SYNC_GLITCH_FLAG_EN
    input  logic         glitch_clr,
    output logic         glitch_flag,
`endif
    output chan_status_t status
);

    localparam int              CNT_W    = cnt_width(DB_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s;
    logic [CNT_W-1:0]       cnt;
    logic                   level_q;
    logic                   rise_q;
    logic                   fall_q;

    assign s = sync_q[SYNC_STAGES-1];

    // Synchroniser chain: bit 0 samples the raw input, MSB is the usable level.
    always_ff @(posedge clk) begin
        if (reset) sync_q <= {SYNC_STAGES{RESET_VAL}};
        else       sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
    end

    // Debounce: accept a new level only after DB_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk) begin
        if (reset) begin
            level_q <= RESET_VAL;
            cnt     <= '0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            if (s == level_q) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level_q <= s;
                cnt     <= '0;
                rise_q  <= s;
                fall_q  <= ~s;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

`ifdef SYNC_GLITCH_FLAG_EN
    // Sticky flag: input fell back before acceptance; clear has priority over set.
    always_ff @(posedge clk) begin
        if (reset)                       glitch_flag <= 1'b0;
        else if (glitch_clr)             glitch_flag <= 1'b0;
        else if (s == level_q && cnt != '0) glitch_flag <= 1'b1;
    end
`endif

    assign status = '{level: level_q, rise: rise_q, fall: fall_q};

endmodule

// File: rtl/multi_sync_debounce.sv
// Multi-channel input conditioner top: N_CH independent sync+debounce channels.
// Optional macro: SYNC_GLITCH_FLAG_EN adds glitch_clr / glitch_flag.
module multi_sync_debounce
    import multi_sync_debounce_pkg::*;
#(
    parameter int   N_CH        = 8,
    parameter int   SYNC_STAGES = 2,
    parameter int   DB_CYCLES   = 16,
    parameter logic RESET_VAL   = 1'b0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_CH-1:0] async_in,
`ifdef SYNC_GLITCH_FLAG_EN
    input  logic            glitch_clr,
    output logic [N_CH-1:0] glitch_flag,
`endif
    output logic [N_CH-1:0] level_out,
    output logic [N_CH-1:0] rise_pulse,
    output logic [N_CH-1:0] fall_pulse
);

    if (SYNC_STAGES < SYNC_MIN_STAGES) begin : g_bad_sync
        $error("multi_sync_debounce: SYNC_STAGES must be >= %0d", SYNC_MIN_STAGES);
    end
    if (DB_CYCLES < DB_MIN_CYCLES) begin : g_bad_db
        $error("multi_sync_debounce: DB_CYCLES must be >= %0d", DB_MIN_CYCLES);
    end
    if (N_CH < 1) begin : g_bad_nch
        $error("multi_sync_debounce: N_CH must be >= 1");
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        chan_status_t st;

        sync_db_chan #(
            .SYNC_STAGES (SYNC_STAGES),
            .DB_CYCLES   (DB_CYCLES),
            .RESET_VAL   (RESET_VAL)
        ) u_chan (
            .clk         (clk),
            .reset       (reset),
            .async_in    (async_in[i]),
`ifdef SYNC_GLITCH_FLAG_EN
            .glitch_clr  (glitch_clr),
            .glitch_flag (glitch_flag[i]),
`endif
            .status      (st)
        );

        assign level_out[i]  = st.level;
        assign rise_pulse[i] = st.rise;
        assign fall_pulse[i] = st.fall;
    end

endmodule

// File: tb/tb_multi_sync_debounce.sv
// Bench for multi_sync_debounce: default 8-channel build (2 sync, 16 debounce)
// plus a 4-channel DB_CYCLES=1 / SYNC_STAGES=3 instance checked against a delay-line model.
module tb_multi_sync_debounce;

    localparam int N  = 8;
    localparam int NB = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic [N-1:0]  async_in, level_out, rise_pulse, fall_pulse;
    logic          reset_b;
    logic [NB-1:0] in_b, lvl_b, rise_b, fall_b;
`ifdef SYNC_GLITCH_FLAG_EN
    logic          glitch_clr, glitch_clr_b;
    logic [N-1:0]  glitch_flag;
    logic [NB-1:0] glitch_flag_b;
`endif

    multi_sync_debounce #(.N_CH(N), .SYNC_STAGES(2), .DB_CYCLES(16), .RESET_VAL(1'b0)) dut (
        .clk(clk), .reset(reset), .async_in(async_in),
`ifdef SYNC_GLITCH_FLAG_EN
        .glitch_clr(glitch_clr), .glitch_flag(glitch_flag),
`endif
        .level_out(level_out), .rise_pulse(rise_pulse), .fall_pulse(fall_pulse)
    );

    multi_sync_debounce #(.N_CH(NB), .SYNC_STAGES(3), .DB_CYCLES(1), .RESET_VAL(1'b0)) dut_b (
        .clk(clk), .reset(reset_b), .async_in(in_b),
`ifdef SYNC_GLITCH_FLAG_EN
        .glitch_clr(glitch_clr_b), .glitch_flag(glitch_flag_b),
`endif
        .level_out(lvl_b), .rise_pulse(rise_b), .fall_pulse(fall_b)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic [N-1:0] din;
        int           hold;
        logic [N-1:0] lvl;
        logic [N-1:0] rise;
        logic [N-1:0] fall;
    } vec_t;

    typedef struct {
        logic [N-1:0] lvl;
        logic [N-1:0] rise;
        logic [N-1:0] fall;
    } exp_t;

    vec_t         vecs[8];
    exp_t         sbq[$];
    exp_t         e;
    logic [N-1:0] cur_lvl;

    logic [NB-1:0] hist[$];
    logic [NB-1:0] eb, prev_b;

    // Drive din for n edges expecting a quiet level hold: no change, no pulses.
    task automatic hold_quiet(input logic [N-1:0] din, input int n, input string name);
        async_in = din;
        for (int k = 0; k < n; k++) begin
            tick();
            check({name, " lvl"}, level_out, cur_lvl);
            check({name, " pulses"}, {rise_pulse, fall_pulse}, '0);
        end
    endtask

    initial begin
        reset    = 1'b1;
        reset_b  = 1'b1;
        async_in = '0;
        in_b     = '0;
`ifdef SYNC_GLITCH_FLAG_EN
        glitch_clr   = 1'b0;
        glitch_clr_b = 1'b0;
`endif
        // From reset level 0. Each record: drive din, run hold edges, expect at the last edge.
        vecs[0] = '{8'h01, 18, 8'h01, 8'h01, 8'h00};  // ch0 clean step, edge 18
        vecs[1] = '{8'h03,  5, 8'h01, 8'h00, 8'h00};  // ch1 short high pulse
        vecs[2] = '{8'h01, 20, 8'h01, 8'h00, 8'h00};  // ch1 returns: rejected
        vecs[3] = '{8'h05, 18, 8'h05, 8'h04, 8'h00};  // ch2 up
        vecs[4] = '{8'h21, 18, 8'h21, 8'h20, 8'h04};  // ch2 down, ch5 up, same edge
        vecs[5] = '{8'h00, 18, 8'h00, 8'h00, 8'h21};  // multi-channel fall
        vecs[6] = '{8'hFF, 18, 8'hFF, 8'hFF, 8'h00};  // all rise
        vecs[7] = '{8'h00, 18, 8'h00, 8'h00, 8'hFF};  // all fall

        // Test 1: reset held 3 clocks
        repeat (3) tick();
        check("reset level", level_out, 8'h00);
        check("reset rise", rise_pulse, 8'h00);
        check("reset fall", fall_pulse, 8'h00);
        reset   = 1'b0;
        cur_lvl = '0;
        tick();
        check("release no pulse", {rise_pulse, fall_pulse}, '0);

        // Table: scoreboard entries pushed as stimulus is driven, popped after each edge
        for (int v = 0; v < 8; v++) begin
            async_in = vecs[v].din;
            for (int k = 1; k <= vecs[v].hold; k++) begin
                if (k == vecs[v].hold) sbq.push_back('{vecs[v].lvl, vecs[v].rise, vecs[v].fall});
                else                   sbq.push_back('{cur_lvl, '0, '0});
                tick();
                e = sbq.pop_front();
                check($sformatf("vec%0d e%0d lvl", v, k), level_out, e.lvl);
                check($sformatf("vec%0d e%0d rise", v, k), rise_pulse, e.rise);
                check($sformatf("vec%0d e%0d fall", v, k), fall_pulse, e.fall);
            end
            cur_lvl = vecs[v].lvl;
`ifdef SYNC_GLITCH_FLAG_EN
            if (v == 2) begin
                check("glitch flag set", glitch_flag, 8'h02);
                glitch_clr = 1'b1;
                tick();
                glitch_clr = 1'b0;
                check("glitch flag cleared", glitch_flag, 8'h00);
            end
`endif
        end
        tick();
        check("pulse one cycle", {rise_pulse, fall_pulse}, '0);

        // Fast toggling on ch4 never reaches DB_CYCLES: level holds
        for (int r = 0; r < 6; r++) begin
            hold_quiet(8'h10, 4, "toggle hi");
            hold_quiet(8'h00, 4, "toggle lo");
        end
        hold_quiet(8'h00, 20, "toggle settle");

        // Test 5: ch3 step, reset asserted at edge 10 discards pending change
        hold_quiet(8'h08, 9, "pre-reset");
        reset = 1'b1;
        tick();
        check("midreset lvl", level_out, 8'h00);
        check("midreset pulses", {rise_pulse, fall_pulse}, '0);
        reset = 1'b0;
        hold_quiet(8'h08, 17, "post-reset");
        tick();
        check("post-reset edge18 lvl", level_out, 8'h08);
        check("post-reset edge18 rise", rise_pulse, 8'h08);
        tick();
        check("post-reset rise drop", rise_pulse, 8'h00);

        // Test 6: DB_CYCLES=1, SYNC_STAGES=3 vs delay-line model (level = input sampled 3 edges earlier)
        in_b = '0;
        repeat (3) tick();
        reset_b = 1'b0;
        repeat (3) hist.push_back('0);
        prev_b = '0;
        for (int c = 0; c < 400; c++) begin
            if (c < 4)           in_b = 4'b0001;
            else if (c % 7 == 0) in_b = in_b;
            else                 in_b = 4'($urandom_range(0, 15));
            tick();
            hist.push_back(in_b);
            eb = hist.pop_front();
            if (c == 2) check("db1 edge3 lvl0", {31'd0, lvl_b[0]}, 32'd0);
            if (c == 3) check("db1 edge4 lvl0", {31'd0, lvl_b[0]}, 32'd1);
            check($sformatf("db1 c%0d lvl", c), lvl_b, eb);
            check($sformatf("db1 c%0d rise", c), rise_b, eb & ~prev_b);
            check($sformatf("db1 c%0d fall", c), fall_b, ~eb & prev_b);
            prev_b = eb;
        end
`ifdef SYNC_GLITCH_FLAG_EN
        check("db1 no glitch", glitch_flag_b, 4'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
